// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: FSM state type and default parameters shared by the ADC capture block
package adc_capture_pkg;
  typedef enum logic [2:0] {IDLE, CNV, WAITB, SHIFT, STORE} state_t;
  localparam int DEF_NCH = 2;
  localparam int DEF_NBITS = 18;
  localparam int DEF_AW = 14;
  localparam int DEF_SCLK_DIV = 2;
  localparam int DEF_CNV_LOW = 4;
  localparam int DEF_BUSY_TMO = 255;
  localparam int CW = 16;
endpackage

// File: rtl/adc_shift_ch.sv
// adc_shift_ch: one channel's MSB-first serial-to-parallel register, exposing the top 16 bits
module adc_shift_ch
  import adc_capture_pkg::*;
#(
  parameter int NBITS = DEF_NBITS
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        en,
  input  logic        din,
  output logic [15:0] top
);
  logic [NBITS-1:0] q;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) q <= '0;
    else if (en) q <= {q[NBITS-2:0], din};
  assign top = q[NBITS-1 -: 16];
endmodule

// File: rtl/adc_serial_capture.sv
// adc_serial_capture: drives shared-bus serial ADCs and streams each sample set into a buffer
module adc_serial_capture
  import adc_capture_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int NBITS    = DEF_NBITS,
  parameter int AW       = DEF_AW,
  parameter int SCLK_DIV = DEF_SCLK_DIV,
  parameter int CNV_LOW  = DEF_CNV_LOW,
  parameter int BUSY_TMO = DEF_BUSY_TMO
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           START,
  input  logic           STOP,
  input  logic           CONT,
  input  logic [15:0]    NSAMP,
  input  logic           PTR_CLR,
  output logic           ADCNVST,
  output logic           ADCS,
  output logic           ADSCLK,
  input  logic [NCH-1:0] ADSDOUT,
  input  logic [NCH-1:0] ADBUSY,
  output logic           MEM_WE,
  output logic [AW-1:0]  MEM_ADRS,
  output logic [15:0]    MEM_DATA,
  output logic [1:0]     MEM_CH,
  output logic           ACTIVE,
  output logic           DONE,
  output logic           TMO_ERR,
  output logic           WRAP
);
  state_t state;
  logic [CW-1:0] cnt;
  logic [5:0] ecnt;
  logic [AW-1:0] adr;
  logic [15:0] nsamp_q, scnt;
  logic cont_q, stop_q, fin, tick, issue, more;
  logic [1:0] wch;
  logic [15:0] sr [4];
  always_comb begin
    fin = ecnt == 6'(2 * NBITS);
    tick = state == SHIFT && cnt == CW'(SCLK_DIV - 1) && !fin;
    issue = (state == SHIFT && fin) || (state == STORE && MEM_CH != 2'(NCH - 1));
    wch = state == STORE ? MEM_CH + 2'd1 : 2'd0;
    more = cont_q && !stop_q && !STOP && (nsamp_q == '0 || scnt + 16'd1 < nsamp_q);
  end
  for (genvar i = 0; i < 4; i++) begin : g_ch
    if (i < NCH) begin : g_on
      adc_shift_ch #(.NBITS(NBITS)) u_sh (
        .CLK(CLK), .RSTN(RSTN), .en(tick && !ADSCLK), .din(ADSDOUT[i]), .top(sr[i])
      );
    end else begin : g_off
      assign sr[i] = '0;
    end
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      cnt <= '0;
      ecnt <= '0;
      adr <= '0;
      nsamp_q <= '0;
      scnt <= '0;
      cont_q <= 1'b0;
      stop_q <= 1'b0;
      ADCNVST <= 1'b1;
      ADCS <= 1'b1;
      ADSCLK <= 1'b0;
      MEM_WE <= 1'b0;
      MEM_ADRS <= '0;
      MEM_DATA <= '0;
      MEM_CH <= '0;
      ACTIVE <= 1'b0;
      DONE <= 1'b0;
      TMO_ERR <= 1'b0;
      WRAP <= 1'b0;
    end else begin
      DONE <= 1'b0;
      MEM_WE <= issue;
      if (state != IDLE && STOP) stop_q <= 1'b1;
      // adr always holds the next free slot; MEM_ADRS shows the word being written
      if (issue) begin
        MEM_ADRS <= adr;
        MEM_CH <= wch;
        MEM_DATA <= sr[wch];
        adr <= adr + AW'(1);
        if (&adr) WRAP <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (PTR_CLR) begin
            adr <= '0;
            MEM_ADRS <= '0;
            WRAP <= 1'b0;
          end
          if (START) begin
            state <= CNV;
            cnt <= '0;
            ADCNVST <= 1'b0;
            ACTIVE <= 1'b1;
            TMO_ERR <= 1'b0;
            cont_q <= CONT;
            nsamp_q <= NSAMP;
            scnt <= '0;
            stop_q <= 1'b0;
          end
        end
        CNV:
          if (cnt == CW'(CNV_LOW - 1)) begin
            state <= WAITB;
            cnt <= '0;
            ADCNVST <= 1'b1;
          end else cnt <= cnt + CW'(1);
        WAITB:
          if (cnt >= CW'(2) && ADBUSY == '0) begin
            state <= SHIFT;
            cnt <= '0;
            ecnt <= '0;
            ADCS <= 1'b0;
          end else if (cnt == CW'(BUSY_TMO + 1)) begin
            state <= IDLE;
            ACTIVE <= 1'b0;
            TMO_ERR <= 1'b1;
          end else cnt <= cnt + CW'(1);
        SHIFT:
          if (fin) begin
            state <= STORE;
            ADCS <= 1'b1;
          end else if (tick) begin
            cnt <= '0;
            ADSCLK <= !ADSCLK;
            ecnt <= ecnt + 6'd1;
          end else cnt <= cnt + CW'(1);
        STORE:
          if (MEM_CH == 2'(NCH - 1)) begin
            scnt <= scnt + 16'd1;
            if (more) begin
              state <= CNV;
              cnt <= '0;
              ADCNVST <= 1'b0;
            end else begin
              state <= IDLE;
              ACTIVE <= 1'b0;
              DONE <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_serial_capture.sv
// tb_adc_serial_capture: directed table-driven bench with a behavioural two-channel ADC model
module tb_adc_serial_capture;
  logic clk = 0, rstn = 0, start = 0, stop = 0, cont = 0, ptr_clr = 0;
  logic [15:0] nsamp = 0;
  logic [1:0] sdout = 0, busy = 0, ch;
  logic cnvst, cs, sclk, we, active, done, tmo, wrap;
  logic [13:0] adrs;
  logic [15:0] data;
  logic start_w = 0, ptr_clr_w = 0;
  logic w_cnvst, w_cs, w_sclk, w_we, w_active, w_done, w_tmo, w_wrap;
  logic [2:0] w_adrs;
  logic [15:0] w_data;
  logic [1:0] w_ch;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  adc_serial_capture dut (
    .CLK(clk), .RSTN(rstn), .START(start), .STOP(stop), .CONT(cont), .NSAMP(nsamp),
    .PTR_CLR(ptr_clr), .ADCNVST(cnvst), .ADCS(cs), .ADSCLK(sclk), .ADSDOUT(sdout),
    .ADBUSY(busy), .MEM_WE(we), .MEM_ADRS(adrs), .MEM_DATA(data), .MEM_CH(ch),
    .ACTIVE(active), .DONE(done), .TMO_ERR(tmo), .WRAP(wrap)
  );
  adc_serial_capture #(.AW(3)) dut_w (
    .CLK(clk), .RSTN(rstn), .START(start_w), .STOP(1'b0), .CONT(1'b1), .NSAMP(16'd5),
    .PTR_CLR(ptr_clr_w), .ADCNVST(w_cnvst), .ADCS(w_cs), .ADSCLK(w_sclk), .ADSDOUT(2'b00),
    .ADBUSY(2'b00), .MEM_WE(w_we), .MEM_ADRS(w_adrs), .MEM_DATA(w_data), .MEM_CH(w_ch),
    .ACTIVE(w_active), .DONE(w_done), .TMO_ERR(w_tmo), .WRAP(w_wrap)
  );

  // ADC model: MSB valid once CS falls, next bit after each falling SCLK; BUSY after CNVST
  logic [17:0] w0 = 0, w1 = 0;
  bit stuck = 0;
  int idx = 0, bcnt = 0;
  logic psclk = 0;
  always @(negedge clk) begin
    if (cs) idx = 0;
    else if (psclk && !sclk) idx++;
    psclk = sclk;
    sdout = idx < 18 ? {w1[17-idx], w0[17-idx]} : 2'b00;
    if (!cnvst) bcnt = 6;
    else if (bcnt > 0) bcnt--;
    busy = stuck ? 2'b11 : {bcnt > 0, bcnt > 1};
  end

  typedef struct {
    bit cont; logic [15:0] nsamp; int stop_set; bit stuck;
    logic [17:0] w0, w1; logic [15:0] d0, d1;
    int nwr, ndone, ncnv; bit tmo;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask

  task automatic run(input vec_t v);
    int nwr = 0, ndone = 0, ncnv = 0, low = 0, sets = 0, waitc = 0, cyc = 0;
    bit pcs = 1, stopped = 0;
    w0 = v.w0; w1 = v.w1; stuck = v.stuck; cont = v.cont; nsamp = v.nsamp;
    @(negedge clk);
    start = 1; ptr_clr = 1;
    do begin
      @(negedge clk);
      cyc++;
      start = cyc == 10;
      ptr_clr = 0;
      stop = 0;
      if (we) begin
        chk("mem_adrs", 32'(adrs), nwr);
        chk("mem_ch", 32'(ch), nwr % 2);
        chk("mem_data", 32'(data), nwr % 2 ? v.d1 : v.d0);
        nwr++;
      end
      if (done) ndone++;
      if (!cnvst) low++;
      else if (low != 0) begin
        chk("cnvst_low_len", low, 4);
        ncnv++;
        low = 0;
      end
      if (active && cnvst && cs) waitc++;
      if (pcs && !cs) sets++;
      pcs = cs;
      if (!stopped && v.stop_set == sets && !cs) begin
        stop = 1;
        stopped = 1;
      end
    end while (active && cyc < 5000);
    stop = 0;
    chk("run_ended", cyc < 5000, 1);
    chk("writes", nwr, v.nwr);
    chk("done_count", ndone, v.ndone);
    chk("cnv_pulses", ncnv, v.ncnv);
    chk("tmo_err", 32'(tmo), 32'(v.tmo));
    if (v.stuck) chk("waitb_len", waitc, 257);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_no_we", 32'(we), 0);
  endtask

  initial begin
    int cyc, nw;
    tbl[0] = '{1'b0, 16'd0, 0, 1'b0, 18'h2A5A5, 18'h15A5A, 16'hA969, 16'h5696, 2, 1, 1, 1'b0};
    tbl[1] = '{1'b1, 16'd3, 0, 1'b0, 18'h12345, 18'h20000, 16'h48D1, 16'h8000, 6, 1, 3, 1'b0};
    tbl[2] = '{1'b1, 16'd1, 0, 1'b0, 18'h3FFFF, 18'h00003, 16'hFFFF, 16'h0000, 2, 1, 1, 1'b0};
    tbl[3] = '{1'b0, 16'd5, 0, 1'b0, 18'h1FFFC, 18'h00004, 16'h7FFF, 16'h0001, 2, 1, 1, 1'b0};
    tbl[4] = '{1'b1, 16'd0, 2, 1'b0, 18'h2A5A5, 18'h15A5A, 16'hA969, 16'h5696, 4, 1, 2, 1'b0};
    tbl[5] = '{1'b0, 16'd0, 0, 1'b1, 18'h2A5A5, 18'h15A5A, 16'hA969, 16'h5696, 0, 0, 1, 1'b1};
    repeat (3) @(negedge clk);
    chk("rst_cnvst", 32'(cnvst), 1);
    chk("rst_cs", 32'(cs), 1);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_mem", {adrs, ch, data}, 0);
    chk("rst_flags", {active, done, tmo, wrap}, 0);
    rstn = 1;
    repeat (3) @(negedge clk);
    chk("idle_inactive", 32'(active), 0);
    for (int k = 0; k < 6; k++) run(tbl[k]);

    // Reset while SCLK is high in the middle of a continuous run
    stuck = 0; cont = 1; nsamp = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (!(!cs && sclk) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_shift", {cs, sclk}, 1);
    rstn = 0;
    #1;
    chk("mid_rst_cs", 32'(cs), 1);
    chk("mid_rst_sclk", 32'(sclk), 0);
    chk("mid_rst_cnvst", 32'(cnvst), 1);
    chk("mid_rst_we", 32'(we), 0);
    chk("mid_rst_adrs", 32'(adrs), 0);
    chk("mid_rst_flags", {active, done, tmo, wrap}, 0);
    repeat (2) @(negedge clk);
    rstn = 1;
    nw = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      nw += int'(we) + int'(active);
    end
    chk("post_rst_idle", nw, 0);

    // Address wrap on the AW=3 instance
    @(negedge clk);
    start_w = 1; ptr_clr_w = 1;
    nw = 0; cyc = 0;
    do begin
      @(negedge clk);
      start_w = 0; ptr_clr_w = 0;
      cyc++;
      if (w_we) begin
        chk("w_adrs", 32'(w_adrs), nw % 8);
        chk("w_wrap", 32'(w_wrap), nw >= 7);
        nw++;
      end
    end while (w_active && cyc < 3000);
    chk("w_writes", nw, 10);
    chk("w_wrap_sticky", 32'(w_wrap), 1);
    ptr_clr_w = 1;
    @(negedge clk);
    ptr_clr_w = 0;
    chk("w_clr_wrap", 32'(w_wrap), 0);
    chk("w_clr_adrs", 32'(w_adrs), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adc_serial_capture.md
ADC_SERIAL_CAPTURE -- requirements
Module: adc_serial_capture

Interface
REQ-001 SHALL have parameter NCH, default 2: number of ADC channels (1..4) sharing CNVST/CS/SCLK.
REQ-002 SHALL have parameter NBITS, default 18: ADC sample width (16..24).
REQ-003 SHALL have parameter AW, default 14: sample-buffer address width.
REQ-004 SHALL have parameter SCLK_DIV, default 2: CLK cycles per SCLK half-period (>=1).
REQ-005 SHALL have parameter CNV_LOW, default 4: CNVST low-pulse length in CLK cycles.
REQ-006 SHALL have parameter BUSY_TMO, default 255: maximum CLK cycles to wait for BUSY release.
REQ-007 CLK  in  1  system clock; one clock domain; all logic on rising edge.
REQ-008 RSTN  in  1  reset, asynchronous assert, active-low.
REQ-009 START  in  1  one-cycle pulse, begins acquisition.
REQ-010 STOP  in  1  level or pulse, ends acquisition after current sample set.
REQ-011 CONT  in  1  1 = continuous mode, 0 = single sample set; sampled on START.
REQ-012 NSAMP  in  16  sample sets per run in continuous mode; 0 = unlimited; sampled on START.
REQ-013 PTR_CLR  in  1  clears write address.
REQ-014 ADCNVST  out  1  conversion start, active-low.
REQ-015 ADCS  out  1  chip select, active-low.
REQ-016 ADSCLK  out  1  serial clock, idle low.
REQ-017 ADSDOUT  in  NCH  serial data, one bit per channel, MSB first.
REQ-018 ADBUSY  in  NCH  conversion busy, active-high, one bit per channel.
REQ-019 MEM_WE  out  1  buffer write strobe, one cycle per word.
REQ-020 MEM_ADRS  out  AW  buffer write address.
REQ-021 MEM_DATA  out  16  sample[NBITS-1:NBITS-16] (top 16 bits).
REQ-022 MEM_CH  out  2  channel index of MEM_DATA.
REQ-023 ACTIVE  out  1  high whenever state is not IDLE.
REQ-024 DONE  out  1  one-cycle pulse on return to IDLE after normal completion.
REQ-025 TMO_ERR  out  1  sticky BUSY-timeout flag, cleared by START.
REQ-026 WRAP  out  1  sticky address-wrap flag, cleared by PTR_CLR.

Function
REQ-027 FSM states SHALL be IDLE, CNV, WAITB, SHIFT, STORE.
REQ-028 IDLE -> CNV on START; START in any other state SHALL be ignored.
REQ-029 CNV: ADCNVST low for exactly CNV_LOW cycles, then high; -> WAITB.
REQ-030 WAITB: ignore ADBUSY for 2 cycles, then -> SHIFT on first cycle with ADBUSY all zero.
REQ-031 WAITB: if ADBUSY nonzero after BUSY_TMO cycles in WAITB -> IDLE, set TMO_ERR, no DONE, no writes.
REQ-032 SHIFT: ADCS low for whole state; ADSCLK toggles every SCLK_DIV cycles, NBITS full periods, ends low.
REQ-033 SHIFT: each channel shift register captures ADSDOUT[i] on CLK edge where ADSCLK goes low->high.
REQ-034 SHIFT -> STORE one cycle after final falling ADSCLK edge; ADCS high on entry to STORE.
REQ-035 STORE: NCH consecutive cycles, MEM_WE=1, MEM_CH = 0..NCH-1 ascending, MEM_ADRS incrementing by 1 after each write.
REQ-036 Address SHALL wrap 2^AW-1 -> 0 and set WRAP on the wrap.
REQ-037 End of STORE: -> CNV if CONT=1, STOP low, and (NSAMP=0 or sets done < NSAMP); else -> IDLE with DONE.
REQ-038 STOP asserted in any non-IDLE state except WAITB timeout SHALL complete current STORE then -> IDLE with DONE.
REQ-039 CONT=0: exactly one sample set (NCH words) per START.
REQ-040 PTR_CLR SHALL act in IDLE only; with START same cycle, first write goes to address 0.
REQ-041 Outputs SHALL be registered; MEM_* valid in same cycle as MEM_WE.

Reset
REQ-042 RSTN low: state IDLE, ADCNVST=1, ADCS=1, ADSCLK=0, MEM_WE=0, MEM_ADRS=0, MEM_DATA=0, MEM_CH=0, ACTIVE=0, DONE=0, TMO_ERR=0, WRAP=0, counters 0.
REQ-043 Reset mid-run SHALL abort immediately without further writes; release resumes in IDLE.

Structure
REQ-044 Package adc_capture_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-045 Per-channel NBITS shift register SHALL be sub-module adc_shift_ch, instantiated NCH times.

Verification
REQ-046 Single: CONT=0, ADC model returns 0x2A5A5 ch0, 0x15A5A ch1 -> two writes: adr0 data 0xA969 ch0, adr1 data 0x5696 ch1, DONE once.
REQ-047 Continuous: CONT=1, NSAMP=3 -> 6 writes adr0..5, CNVST pulses 3 times, each low 4 cycles, one DONE.
REQ-048 Timeout: ADBUSY stuck high -> IDLE after 2+255 WAITB cycles, TMO_ERR=1, no MEM_WE, no DONE.
REQ-049 Wrap: AW=3, CONT=1, NSAMP=5 -> addresses 0..7,0,1; WRAP=1 on 8th write; PTR_CLR then clears WRAP and address.
REQ-050 STOP during SHIFT of set 2 (NSAMP=0) -> set 2 fully stored (4 words total), then IDLE with DONE.
REQ-051 RSTN low during SHIFT -> ADCS=1, ADSCLK=0, no MEM_WE, all flags 0.
